// File: rtl/clip_seq_pkg.sv
// Shared types and helpers for the clip memory sequencer: FSM state encoding,
// default widths and the clip base-address helper.
package clip_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REC      = 2'd1,
      PLAY_RD  = 2'd2,
      PLAY_OUT = 2'd3
   } state_e;

   localparam int DEF_ADDR_W    = 17;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_NUM_CLIPS = 2;
   localparam int CLIP_W        = $clog2(DEF_NUM_CLIPS);

   // Each slot owns an aligned power-of-two region, so its base is the slot index shifted up.
   function automatic logic [31:0] clip_base(input logic [31:0] clip,
                                             input int unsigned shift = DEF_ADDR_W - CLIP_W);
      return clip << shift;
   endfunction

endpackage

// File: rtl/clip_memory_sequencer_len.sv
// Per-clip recorded-length table: one write port, one combinational read port,
// every entry cleared by reset.
module clip_len_table #(
   parameter int NUM_CLIPS = 2,
   parameter int IDX_W     = 1,
   parameter int LEN_W     = 17
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wen_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [LEN_W-1:0] wlen_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [LEN_W-1:0] rlen_o
);

   logic [LEN_W-1:0] len_q [NUM_CLIPS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
      end else if (wen_i) begin
         len_q[widx_i] <= wlen_i;
      end
   end

   assign rlen_o = len_q[ridx_i];

endmodule

// File: rtl/clip_memory_sequencer.sv
// Sequences record (deserializer -> RAM) and playback (RAM -> serializer) over a
// single-port sample RAM. Define CLIP_LOOP_PLAY_EN to add the looping-playback input.
module clip_memory_sequencer
   import clip_seq_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_CLIPS = DEF_NUM_CLIPS
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start_record,
   input  logic                         start_play,
   input  logic                         stop,
   input  logic [$clog2(NUM_CLIPS)-1:0] clip_sel,
`ifdef CLIP_LOOP_PLAY_EN
   input  logic                         loop,
`endif
   input  logic                         rec_valid,
   input  logic [DATA_W-1:0]            rec_data,
   output logic                         rec_ready,
   output logic                         play_valid,
   output logic [DATA_W-1:0]            play_data,
   input  logic                         play_ready,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic                         mem_we,
   output logic                         mem_re,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         busy,
   output logic                         done
);

   localparam int          SEL_W      = $clog2(NUM_CLIPS);
   localparam int          CLIP_DEPTH = (2**ADDR_W) / NUM_CLIPS;
   localparam int          CNT_W      = $clog2(CLIP_DEPTH) + 1;
   localparam int unsigned OFF_W      = ADDR_W - SEL_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CLIP_DEPTH);

   state_e             state_q;
   logic [SEL_W-1:0]   clip_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               rec_ready_q, play_valid_q, mem_re_q, busy_q, done_q, fwd_q;
   logic [DATA_W-1:0]  pdata_q;

   logic               rec_fire, play_fire, rec_exit, loop_en, len_we;
   logic [CNT_W-1:0]   cnt_inc, cur_len, len_wdata;
   logic [SEL_W-1:0]   len_ridx;

`ifdef CLIP_LOOP_PLAY_EN
   assign loop_en = loop;
`else
   assign loop_en = 1'b0;
`endif

   assign cnt_inc   = cnt_q + 1'b1;
   assign rec_fire  = rec_ready_q & rec_valid;
   assign play_fire = play_valid_q & play_ready;
   // A write landing in the stop cycle is included in the recorded length.
   assign rec_exit  = (state_q == REC) & (stop | (rec_fire & (cnt_inc == DEPTH_C)));
   assign len_we    = rec_exit;
   assign len_wdata = rec_fire ? cnt_inc : cnt_q;
   assign len_ridx  = (state_q == IDLE) ? clip_sel : clip_q;

   clip_len_table #(
      .NUM_CLIPS (NUM_CLIPS),
      .IDX_W     (SEL_W),
      .LEN_W     (CNT_W)
   ) u_len (
      .clock  (clock),
      .reset  (reset),
      .wen_i  (len_we),
      .widx_i (clip_q),
      .wlen_i (len_wdata),
      .ridx_i (len_ridx),
      .rlen_o (cur_len)
   );

   assign mem_addr   = ADDR_W'(clip_base(32'(clip_q), OFF_W)) + ADDR_W'(cnt_q);
   assign mem_we     = rec_fire;
   assign mem_wdata  = rec_fire ? rec_data : '0;
   assign mem_re     = mem_re_q;
   assign rec_ready  = rec_ready_q;
   assign play_valid = play_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   // RAM data arrives during the first PLAY_OUT cycle; forward it, then hold the captured copy.
   assign play_data  = fwd_q ? mem_rdata : pdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         clip_q       <= '0;
         cnt_q        <= '0;
         rec_ready_q  <= 1'b0;
         play_valid_q <= 1'b0;
         mem_re_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fwd_q        <= 1'b0;
         pdata_q      <= '0;
      end else begin
         done_q <= 1'b0;
         fwd_q  <= 1'b0;
         if (fwd_q) pdata_q <= mem_rdata;
         unique case (state_q)
            IDLE: begin
               if (start_record) begin
                  clip_q      <= clip_sel;
                  cnt_q       <= '0;
                  state_q     <= REC;
                  rec_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else if (start_play) begin
                  clip_q <= clip_sel;
                  cnt_q  <= '0;
                  if (cur_len != '0) begin
                     state_q  <= PLAY_RD;
                     mem_re_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            REC: begin
               if (rec_fire) cnt_q <= cnt_inc;
               if (rec_exit) begin
                  state_q     <= IDLE;
                  rec_ready_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            PLAY_RD: begin
               mem_re_q <= 1'b0;
               if (stop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q      <= PLAY_OUT;
                  play_valid_q <= 1'b1;
                  fwd_q        <= 1'b1;
               end
            end
            PLAY_OUT: begin
               if (stop) begin
                  state_q      <= IDLE;
                  play_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end else if (play_fire) begin
                  play_valid_q <= 1'b0;
                  cnt_q        <= cnt_inc;
                  if (cnt_inc == cur_len && !loop_en) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     if (cnt_inc == cur_len) cnt_q <= '0;
                     state_q  <= PLAY_RD;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clip_memory_sequencer.sv
// Scoreboard bench for clip_memory_sequencer: expected RAM writes, RAM reads and
// playback samples are queued as stimulus is driven and checked as the DUT produces them.
module tb_clip_memory_sequencer;

   logic        clock;
   logic        reset;
   logic        start_record, start_play, stop;
   logic [0:0]  clip_sel;
   logic        loop_i;
   logic        rec_valid;
   logic [15:0] rec_data;
   logic        rec_ready;
   logic        play_valid;
   logic [15:0] play_data;
   logic        play_ready;
   logic [16:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we, mem_re;
   logic [15:0] mem_rdata;
   logic        busy, done;

   clip_memory_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .start_record (start_record),
      .start_play   (start_play),
      .stop         (stop),
      .clip_sel     (clip_sel),
`ifdef CLIP_LOOP_PLAY_EN
      .loop         (loop_i),
`endif
      .rec_valid    (rec_valid),
      .rec_data     (rec_data),
      .rec_ready    (rec_ready),
      .play_valid   (play_valid),
      .play_data    (play_data),
      .play_ready   (play_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_rdata    (mem_rdata),
      .busy         (busy),
      .done         (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Environment RAM: synchronous write, read data valid the cycle after mem_re.
   logic [15:0] ram [0:131071];
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] exp_play[$];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_play  = 0;
   int          ready_mode = 0;
   int          tcnt = 0;
   logic        held_vld = 1'b0;
   logic [15:0] held_data = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      wr_t         w;
      logic [31:0] a;
      if (mem_we && mem_re) check_eq("we_re_exclusive", 32'(mem_re), 32'd0);
      if (mem_we) begin
         if (exp_wr.size() == 0) check_eq("wr_unexpected_addr", 32'(mem_addr), 32'hFFFF_FFFF);
         else begin
            w = exp_wr.pop_front();
            check_eq("wr_addr", 32'(mem_addr), w.addr);
            check_eq("wr_data", 32'(mem_wdata), w.data);
         end
      end
      if (mem_re) begin
         if (exp_rd.size() == 0) check_eq("rd_unexpected_addr", 32'(mem_addr), 32'hFFFF_FFFF);
         else begin
            a = exp_rd.pop_front();
            check_eq("rd_addr", 32'(mem_addr), a);
         end
      end
      if (play_valid && held_vld) check_eq("play_hold", 32'(play_data), 32'(held_data));
      if (play_valid && play_ready) begin
         n_play++;
         if (exp_play.size() == 0) check_eq("play_unexpected", 32'(play_data), 32'hFFFF_FFFF);
         else begin
            a = exp_play.pop_front();
            check_eq("play_data", 32'(play_data), a);
         end
      end
      held_vld  = play_valid && !play_ready;
      held_data = play_data;
   endtask

   // One clock: observe at the falling edge, then return just after the rising edge.
   task automatic step();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      if (ready_mode == 1) begin
         tcnt++;
         if (tcnt == 3) begin
            tcnt = 0;
            play_ready = ~play_ready;
         end
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         step();
         k++;
      end
      check_eq(tag, 32'(done), 32'd1);
   endtask

   task automatic push_play(input logic [31:0] base, input logic [15:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(base + 32'(i));
         exp_play.push_back(32'(first + 16'(i)));
      end
   endtask

   task automatic pulse_play(input logic [0:0] clip);
      clip_sel   = clip;
      start_play = 1'b1;
      step();
      start_play = 1'b0;
   endtask

   int play_base;

   initial begin
      reset = 1'b1; start_record = 0; start_play = 0; stop = 0; clip_sel = 0;
      loop_i = 0; rec_valid = 0; rec_data = 0; play_ready = 1'b1;
      step(); step();
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_outs", {28'd0, rec_ready, play_valid, mem_we, mem_re}, 0);
      check_eq("rst_addr", 32'(mem_addr), 0);
      check_eq("rst_play_data", 32'(play_data), 0);
      reset = 1'b0;
      step();

      // Empty clip after reset: done next cycle, never busy, no read.
      pulse_play(1'b0);
      check_eq("empty_done", 32'(done), 1);
      check_eq("empty_busy", 32'(busy), 0);
      step();
      check_eq("empty_done_pulse", 32'(done), 0);

      // Record clip 0: five samples, then stop.
      clip_sel = 0; start_record = 1'b1;
      step();
      start_record = 1'b0;
      check_eq("rec0_ready", 32'(rec_ready), 1);
      check_eq("rec0_busy", 32'(busy), 1);
      for (int i = 1; i <= 5; i++) begin
         rec_valid = 1'b1; rec_data = 16'(i);
         exp_wr.push_back('{addr: 32'(i - 1), data: 32'(i)});
         step();
      end
      rec_valid = 1'b0; stop = 1'b1;
      step();
      stop = 1'b0;
      check_eq("rec0_done", 32'(done), 1);
      check_eq("rec0_idle", {30'd0, busy, rec_ready}, 0);
      check_eq("rec0_wr_left", 32'(exp_wr.size()), 0);

      // Play clip 0 with ready held high.
      push_play(32'h0, 16'h0001, 5);
      play_base = n_play;
      pulse_play(1'b0);
      wait_done("play0_done", 40);
      check_eq("play0_busy", 32'(busy), 0);
      check_eq("play0_count", 32'(n_play - play_base), 5);
      check_eq("play0_left", 32'(exp_play.size() + exp_rd.size()), 0);
      step();
      check_eq("play0_done_pulse", 32'(done), 0);

      // Simultaneous commands favour record; start_play mid-record is ignored; stop-cycle write counts.
      clip_sel = 1; start_record = 1'b1; start_play = 1'b1;
      step();
      start_record = 1'b0; start_play = 1'b0;
      check_eq("both_rec_ready", 32'(rec_ready), 1);
      check_eq("both_no_re", 32'(mem_re), 0);
      for (int i = 0; i < 3; i++) begin
         rec_valid = 1'b1; rec_data = 16'hA001 + 16'(i);
         start_play = (i == 0);
         stop = (i == 2);
         exp_wr.push_back('{addr: 32'h10000 + 32'(i), data: 32'(16'hA001 + 16'(i))});
         step();
      end
      rec_valid = 1'b0; stop = 1'b0; start_play = 1'b0;
      check_eq("rec1_done", 32'(done), 1);
      check_eq("rec1_wr_left", 32'(exp_wr.size()), 0);

      // Play clip 1 with ready toggling every three cycles.
      ready_mode = 1; tcnt = 0; play_ready = 1'b0;
      push_play(32'h10000, 16'hA001, 3);
      play_base = n_play;
      pulse_play(1'b1);
      wait_done("play1_done", 100);
      check_eq("play1_count", 32'(n_play - play_base), 3);
      check_eq("play1_left", 32'(exp_play.size() + exp_rd.size()), 0);
      ready_mode = 0; play_ready = 1'b1;
      step();

      // Stop during playback: valid drops without a handshake.
      ready_mode = 2; play_ready = 1'b0;
      exp_rd.push_back(32'h0);
      pulse_play(1'b0);
      step();
      check_eq("abort_valid", 32'(play_valid), 1);
      check_eq("abort_data", 32'(play_data), 32'h0001);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_eq("abort_done", 32'(done), 1);
      check_eq("abort_idle", {30'd0, busy, play_valid}, 0);
      ready_mode = 0; play_ready = 1'b1;
      step();

      // Reset in the middle of a recording.
      clip_sel = 1; start_record = 1'b1;
      step();
      start_record = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rec_valid = 1'b1; rec_data = 16'hB001 + 16'(i);
         exp_wr.push_back('{addr: 32'h10000 + 32'(i), data: 32'(16'hB001 + 16'(i))});
         step();
      end
      rec_valid = 1'b0; reset = 1'b1;
      step();
      rec_valid = 1'b1;
      check_eq("midrst_outs", {27'd0, rec_ready, play_valid, mem_we, mem_re, busy}, 0);
      check_eq("midrst_done", 32'(done), 0);
      check_eq("midrst_addr", 32'(mem_addr), 0);
      rec_valid = 1'b0; reset = 1'b0;
      step();
      check_eq("midrst_no_done", 32'(done), 0);
      pulse_play(1'b0);
      check_eq("cleared0_done", 32'(done), 1);
      check_eq("cleared0_busy", 32'(busy), 0);
      step();
      pulse_play(1'b1);
      check_eq("cleared1_done", 32'(done), 1);
      check_eq("cleared1_busy", 32'(busy), 0);
      step();

      // Fill clip 0 completely; recording ends on the last write by itself.
      clip_sel = 0; start_record = 1'b1;
      step();
      start_record = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         rec_valid = 1'b1; rec_data = 16'(i) ^ 16'h5A5A;
         exp_wr.push_back('{addr: 32'(i), data: 32'(16'(i) ^ 16'h5A5A)});
         step();
      end
      check_eq("fill_done", 32'(done), 1);
      check_eq("fill_idle", {30'd0, busy, rec_ready}, 0);
      check_eq("fill_no_we", 32'(mem_we), 0);
      step();
      rec_valid = 1'b0;
      check_eq("fill_wr_left", 32'(exp_wr.size()), 0);
      check_eq("fill_len", 32'(dut.u_len.len_q[0]), 32'd65536);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
